// File: rtl/x_src_pkg.sv
// x_src_pkg: shared state encoding and counter width for the x stream source
package x_src_pkg;
  typedef enum logic [1:0] {LOAD, PRIME, SEND} x_src_state_t;
  localparam int VEC_CNT_W = 8;
endpackage

// File: rtl/x_src_buffer.sv
// x_src_buffer: 1-write/1-read sample RAM with registered, enabled read port
module x_src_buffer
  import x_src_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  // write port and read port; read data holds when rd_en is low so it doubles as the prefetch slot
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/x_stream_source.sv
// x_stream_source: loads one LENX vector, replays it as a valid/ready stream (replay option: X_SRC_REPLAY_EN)
module x_stream_source
  import x_src_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LENX  = 8,
  parameter int ADDRX = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     s_data_ld,
  input  logic                 s_valid_ld,
  output logic                 s_ready_ld,
  output logic [WIDTH-1:0]     m_data_out_x,
  output logic                 m_valid_x,
  input  logic                 m_ready_x,
  input  logic                 replay,
  output logic                 vec_done,
  output logic [VEC_CNT_W-1:0] vec_count
);
  localparam logic [ADDRX-1:0] LAST = ADDRX'(LENX - 1);
  logic [1:0] rst_q;
  logic rst_i;
  x_src_state_t state, state_nx;
  logic [ADDRX-1:0] wr_ptr, rd_ptr, out_idx;
  logic [WIDTH-1:0] rd_data;
  logic pf_valid, rd_more, ld_fire, out_fire, out_last, load_out, rd_en, replay_go;
`ifdef X_SRC_REPLAY_EN
  assign replay_go = replay;
`else
  logic unused_replay;
  assign unused_replay = replay;
  assign replay_go = 1'b0;
`endif
  assign rst_i      = rst_q[1];
  assign s_ready_ld = rst_i && state == LOAD;
  assign ld_fire    = s_valid_ld && s_ready_ld;
  assign out_fire   = m_valid_x && m_ready_x;
  assign out_last   = out_fire && out_idx == LAST;
  assign vec_done   = out_last;
  assign load_out   = state == SEND && pf_valid && (!m_valid_x || m_ready_x);
  assign rd_en      = state == PRIME || (load_out && rd_more);
  x_src_buffer #(.WIDTH(WIDTH), .DEPTH(LENX), .AW(ADDRX)) u_buf (
    .clk(clk), .wr_en(ld_fire), .wr_addr(wr_ptr), .wr_data(s_data_ld),
    .rd_en(rd_en), .rd_addr(rd_ptr), .rd_data(rd_data)
  );
  // reset synchronizer: asserts asynchronously, releases on the clock
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  // state register
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) state <= LOAD;
    else state <= state_nx;
  // next state: fill, prime the read pipe, stream until the last sample leaves
  always_comb begin
    state_nx = state;
    if (state == LOAD && ld_fire && wr_ptr == LAST) state_nx = PRIME;
    else if (state == PRIME) state_nx = SEND;
    else if (out_last) state_nx = replay_go ? PRIME : LOAD;
  end
  // pointers, prefetch flag, output register and vector counter
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_idx      <= '0;
      rd_more      <= 1'b0;
      pf_valid     <= 1'b0;
      m_valid_x    <= 1'b0;
      m_data_out_x <= '0;
      vec_count    <= '0;
    end else begin
      if (ld_fire) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      rd_more  <= state == PRIME ? 1'b1 : (rd_en && rd_ptr == LAST) ? 1'b0 : rd_more;
      pf_valid <= rd_en ? 1'b1 : load_out ? 1'b0 : pf_valid;
      if (load_out) m_data_out_x <= rd_data;
      m_valid_x <= load_out ? 1'b1 : out_fire ? 1'b0 : m_valid_x;
      if (out_fire) out_idx <= out_idx == LAST ? '0 : out_idx + 1'b1;
      if (out_last) vec_count <= vec_count + 1'b1;
    end
endmodule
